// File: rtl/free_list_pkg.sv
// Shared types and constants for the rename free list (PHYS_TAG, FL_CNT, pointer math).
// The optional checker in free_list is enabled by defining FREE_LIST_CHECK_EN.
package free_list_pkg;

    localparam int unsigned N           = 3;
    localparam int unsigned ARCH_REG_SZ = 32;
    localparam int unsigned PHYS_REG_SZ = 64;
    localparam int unsigned FL_DEPTH    = PHYS_REG_SZ - ARCH_REG_SZ;

    localparam int unsigned TAG_W    = $clog2(PHYS_REG_SZ);
    localparam int unsigned PTR_W    = $clog2(FL_DEPTH);
    localparam int unsigned FL_CNT_W = $clog2(FL_DEPTH + 1);

    typedef logic [TAG_W-1:0]    PHYS_TAG;
    typedef logic [PTR_W-1:0]    FL_PTR;
    typedef logic [FL_CNT_W-1:0] FL_CNT;

    // Modulo-FL_DEPTH add by compare-and-subtract; inc never exceeds FL_DEPTH.
    function automatic FL_PTR ptr_add(input FL_PTR p, input FL_CNT inc);
        logic [FL_CNT_W:0] s;
        s = (FL_CNT_W + 1)'(p) + (FL_CNT_W + 1)'(inc);
        if (s >= (FL_CNT_W + 1)'(FL_DEPTH))
            s = s - (FL_CNT_W + 1)'(FL_DEPTH);
        return FL_PTR'(s);
    endfunction

endpackage

// File: rtl/free_list_compact.sv
// Prefix-sum compaction: offset[k] is the number of set enables below port k.
module free_list_compact
    import free_list_pkg::*;
#(
    parameter  int unsigned WIDTH = 3,
    localparam int unsigned OW    = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] en,
    output logic [OW-1:0]    offset [WIDTH],
    output logic [OW-1:0]    total
);

    always_comb begin
        logic [OW-1:0] acc;
        acc = '0;
        for (int unsigned k = 0; k < WIDTH; k++) begin
            offset[k] = acc;
            acc       = acc + OW'(en[k]);
        end
        total = acc;
    end

endmodule

// File: rtl/free_list.sv
// Circular free list of physical tags with speculative/committed heads and restore.
// Define FREE_LIST_CHECK_EN to add the sticky fl_error illegal-input monitor.
module free_list
    import free_list_pkg::*;
#(
    parameter int unsigned NUM_ALLOC_PORTS  = N,
    parameter int unsigned NUM_RETIRE_PORTS = N
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [NUM_ALLOC_PORTS-1:0]  alloc_req,
    output PHYS_TAG                     alloc_tags [NUM_ALLOC_PORTS],
    output logic                        alloc_ok,
    output FL_CNT                       free_count,
    input  logic [NUM_RETIRE_PORTS-1:0] retire_en,
    input  PHYS_TAG                     retire_old_tags [NUM_RETIRE_PORTS],
    input  logic                        restore_en
`ifdef FREE_LIST_CHECK_EN
    ,
    output logic                        fl_error
`endif
);

    localparam int unsigned AOW = $clog2(NUM_ALLOC_PORTS + 1);
    localparam int unsigned ROW = $clog2(NUM_RETIRE_PORTS + 1);

    logic [AOW-1:0] a_off [NUM_ALLOC_PORTS];
    logic [AOW-1:0] a_total;
    logic [ROW-1:0] r_off [NUM_RETIRE_PORTS];
    logic [ROW-1:0] r_total;

    PHYS_TAG fl_buf [FL_DEPTH];
    FL_PTR   head, arch_head, tail;
    FL_PTR   arch_head_next, tail_next;
    FL_CNT   inflight;
    FL_CNT   a_cnt, r_cnt;

    free_list_compact #(.WIDTH(NUM_ALLOC_PORTS)) u_alloc_compact (
        .en     (alloc_req),
        .offset (a_off),
        .total  (a_total)
    );

    free_list_compact #(.WIDTH(NUM_RETIRE_PORTS)) u_retire_compact (
        .en     (retire_en),
        .offset (r_off),
        .total  (r_total)
    );

    assign a_cnt          = FL_CNT'(a_total);
    assign r_cnt          = FL_CNT'(r_total);
    assign alloc_ok       = (a_cnt <= free_count);
    assign arch_head_next = ptr_add(arch_head, r_cnt);
    assign tail_next      = ptr_add(tail, r_cnt);

    // Unrequested ports show buf[head+k] so an idle cycle lists the next tags in order.
    always_comb begin
        for (int unsigned k = 0; k < NUM_ALLOC_PORTS; k++) begin
            alloc_tags[k] = fl_buf[ptr_add(head, alloc_req[k] ? FL_CNT'(a_off[k]) : FL_CNT'(k))];
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int unsigned i = 0; i < FL_DEPTH; i++)
                fl_buf[FL_PTR'(i)] <= PHYS_TAG'(ARCH_REG_SZ + i);
            head       <= '0;
            arch_head  <= '0;
            tail       <= '0;
            free_count <= FL_CNT'(FL_DEPTH);
            inflight   <= '0;
        end else begin
            for (int unsigned k = 0; k < NUM_RETIRE_PORTS; k++) begin
                if (retire_en[k])
                    fl_buf[ptr_add(tail, FL_CNT'(r_off[k]))] <= retire_old_tags[k];
            end
            tail      <= tail_next;
            arch_head <= arch_head_next;
            // inflight counts allocated-not-retired tags, so restore returns
            // (inflight - r_cnt) plus r_cnt freed: count + inflight in total.
            if (restore_en) begin
                head       <= arch_head_next;
                free_count <= free_count + inflight;
                inflight   <= '0;
            end else if (alloc_ok) begin
                head       <= ptr_add(head, a_cnt);
                free_count <= free_count - a_cnt + r_cnt;
                inflight   <= inflight + a_cnt - r_cnt;
            end else begin
                free_count <= free_count + r_cnt;
                inflight   <= inflight - r_cnt;
            end
        end
    end

`ifdef FREE_LIST_CHECK_EN
    localparam logic [FL_CNT_W:0] DEPTH_X = (FL_CNT_W + 1)'(FL_DEPTH);

    logic tag0_free, free_ovf, restore_ovf;

    always_comb begin
        tag0_free = 1'b0;
        for (int unsigned k = 0; k < NUM_RETIRE_PORTS; k++) begin
            if (retire_en[k] && (retire_old_tags[k] == '0))
                tag0_free = 1'b1;
        end
        free_ovf    = ({1'b0, free_count} + {1'b0, r_cnt}) > DEPTH_X;
        restore_ovf = restore_en && (({1'b0, free_count} + {1'b0, inflight}) > DEPTH_X);
    end

    always_ff @(posedge clock) begin
        if (!reset)
            fl_error <= 1'b0;
        else if (tag0_free || free_ovf || restore_ovf)
            fl_error <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_free_list.sv
// Self-checking bench for free_list against a queue-based model of the free tag pool.
module tb_free_list;
    import free_list_pkg::*;

    localparam int D = 32;

    logic    clock = 1'b0;
    logic    reset;
    logic [2:0] alloc_req;
    PHYS_TAG alloc_tags [3];
    logic    alloc_ok;
    FL_CNT   free_count;
    logic [2:0] retire_en;
    PHYS_TAG retire_old_tags [3];
    logic    restore_en;
`ifdef FREE_LIST_CHECK_EN
    logic    fl_error;
`endif

    int errors = 0;
    int checks = 0;

    // Model: m_lst holds tags from the committed head onward; the first
    // m_inflight entries are speculatively allocated, the rest are free.
    int m_lst[$];
    int m_inflight;

    free_list #(.NUM_ALLOC_PORTS(3), .NUM_RETIRE_PORTS(3)) dut (
        .clock           (clock),
        .reset           (reset),
        .alloc_req       (alloc_req),
        .alloc_tags      (alloc_tags),
        .alloc_ok        (alloc_ok),
        .free_count      (free_count),
        .retire_en       (retire_en),
        .retire_old_tags (retire_old_tags),
        .restore_en      (restore_en)
`ifdef FREE_LIST_CHECK_EN
        ,
        .fl_error        (fl_error)
`endif
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void m_reset();
        m_lst.delete();
        for (int i = 0; i < D; i++) m_lst.push_back(32 + i);
        m_inflight = 0;
    endfunction

    function automatic int m_free();
        return D - m_inflight;
    endfunction

    // Index into the free region offered to port k for the present request.
    function automatic int m_idx(int k);
        int n;
        if (!alloc_req[k]) return k;
        n = 0;
        for (int j = 0; j < k; j++) if (alloc_req[j]) n++;
        return n;
    endfunction

    function automatic int m_tag(int k);
        return m_lst[(m_inflight + m_idx(k)) % D];
    endfunction

    task automatic clear_inputs();
        alloc_req  = '0;
        retire_en  = '0;
        restore_en = 1'b0;
        for (int k = 0; k < 3; k++) retire_old_tags[k] = '0;
    endtask

    task automatic tick();
        int a, r;
        bit ok;
        @(posedge clock);
        if (!reset) begin
            m_reset();
        end else begin
            a  = $countones(alloc_req);
            r  = $countones(retire_en);
            ok = (a <= m_free());
            for (int i = 0; i < r; i++) void'(m_lst.pop_front());
            for (int k = 0; k < 3; k++)
                if (retire_en[k]) m_lst.push_back(int'(retire_old_tags[k]));
            if (restore_en)  m_inflight = 0;
            else if (ok)     m_inflight = m_inflight + a - r;
            else             m_inflight = m_inflight - r;
        end
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        clear_inputs();
        tick();
        tick();
        reset = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (alloc_tags[k] !== PHYS_TAG'(32 + k)) begin
                errors++;
                $display("FAIL reset_tag[%0d]: got %0d expected %0d", k, alloc_tags[k], 32 + k);
            end
        end
        checks++;
        if (free_count !== FL_CNT'(32)) begin
            errors++;
            $display("FAIL reset_count: got %0d expected 32", free_count);
        end
        checks++;
        if (alloc_ok !== 1'b1) begin
            errors++;
            $display("FAIL reset_ok: got %0b expected 1", alloc_ok);
        end
    endtask

    task automatic test_alloc();
        alloc_req = 3'b101;
        #1;
        checks++;
        if (alloc_tags[0] !== PHYS_TAG'(32) || alloc_tags[2] !== PHYS_TAG'(33)) begin
            errors++;
            $display("FAIL alloc_tags: got %0d/%0d expected 32/33", alloc_tags[0], alloc_tags[2]);
        end
        tick();
        alloc_req = '0;
        #1;
        checks++;
        if (free_count !== FL_CNT'(30) || alloc_tags[0] !== PHYS_TAG'(34)) begin
            errors++;
            $display("FAIL alloc_after: got count %0d tag %0d expected 30 34", free_count, alloc_tags[0]);
        end
    endtask

    task automatic test_drain();
        do_reset();
        alloc_req = 3'b111;
        for (int i = 0; i < 10; i++) tick();
        #1;
        checks++;
        if (alloc_ok !== 1'b0) begin
            errors++;
            $display("FAIL drain_ok_3of2: got %0b expected 0", alloc_ok);
        end
        alloc_req = 3'b011;
        #1;
        checks++;
        if (alloc_ok !== 1'b1) begin
            errors++;
            $display("FAIL drain_ok_2of2: got %0b expected 1", alloc_ok);
        end
        tick();
        alloc_req = '0;
        #1;
        checks++;
        if (free_count !== FL_CNT'(0)) begin
            errors++;
            $display("FAIL drain_count: got %0d expected 0", free_count);
        end
        alloc_req = 3'b001;
        #1;
        checks++;
        if (alloc_ok !== 1'b0) begin
            errors++;
            $display("FAIL empty_ok: got %0b expected 0", alloc_ok);
        end
        tick();
        checks++;
        if (free_count !== FL_CNT'(0)) begin
            errors++;
            $display("FAIL empty_hold: got %0d expected 0", free_count);
        end
    endtask

    task automatic test_retire_then_alloc();
        alloc_req          = 3'b111;
        retire_en          = 3'b011;
        retire_old_tags[0] = PHYS_TAG'(5);
        retire_old_tags[1] = PHYS_TAG'(9);
        #1;
        checks++;
        if (alloc_ok !== 1'b0) begin
            errors++;
            $display("FAIL retire_same_cycle_ok: got %0b expected 0", alloc_ok);
        end
        tick();
        clear_inputs();
        #1;
        checks++;
        if (free_count !== FL_CNT'(2) || alloc_tags[0] !== PHYS_TAG'(5) || alloc_tags[1] !== PHYS_TAG'(9)) begin
            errors++;
            $display("FAIL retire_next: got count %0d tags %0d/%0d expected 2 5/9",
                     free_count, alloc_tags[0], alloc_tags[1]);
        end
    endtask

    task automatic test_restore();
        do_reset();
        alloc_req = 3'b111;
        tick();
        tick();
        alloc_req          = '0;
        retire_en          = 3'b011;
        retire_old_tags[0] = PHYS_TAG'(3);
        retire_old_tags[1] = PHYS_TAG'(4);
        tick();
        retire_en          = 3'b001;
        retire_old_tags[0] = PHYS_TAG'(7);
        alloc_req          = 3'b111;
        restore_en         = 1'b1;
        tick();
        clear_inputs();
        #1;
        checks++;
        if (free_count !== FL_CNT'(32)) begin
            errors++;
            $display("FAIL restore_count: got %0d expected 32", free_count);
        end
        checks++;
        if (alloc_tags[0] !== PHYS_TAG'(35) || alloc_tags[1] !== PHYS_TAG'(36)) begin
            errors++;
            $display("FAIL restore_head: got %0d/%0d expected 35/36", alloc_tags[0], alloc_tags[1]);
        end
        checks++;
        if (alloc_tags[0] !== PHYS_TAG'(m_tag(0)) || free_count !== FL_CNT'(m_free())) begin
            errors++;
            $display("FAIL restore_model: got %0d/%0d expected %0d/%0d",
                     alloc_tags[0], free_count, m_tag(0), m_free());
        end
    endtask

    task automatic test_random();
        logic [2:0] ren;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            alloc_req = 3'($urandom_range(0, 7));
            ren       = 3'($urandom_range(0, 7));
            while ($countones(ren) > m_inflight) ren = ren & (ren - 3'd1);
            retire_en = ren;
            for (int k = 0; k < 3; k++) retire_old_tags[k] = PHYS_TAG'($urandom_range(1, 63));
            restore_en = ($urandom_range(0, 15) == 0);
            #1;
            checks++;
            if (alloc_ok !== ($countones(alloc_req) <= m_free())) begin
                errors++;
                $display("FAIL rand_ok c=%0d: got %0b expected %0b", c, alloc_ok,
                         $countones(alloc_req) <= m_free());
            end
            checks++;
            if (free_count !== FL_CNT'(m_free())) begin
                errors++;
                $display("FAIL rand_count c=%0d: got %0d expected %0d", c, free_count, m_free());
            end
            for (int k = 0; k < 3; k++) begin
                if (m_idx(k) < m_free()) begin
                    checks++;
                    if (alloc_tags[k] !== PHYS_TAG'(m_tag(k))) begin
                        errors++;
                        $display("FAIL rand_tag[%0d] c=%0d: got %0d expected %0d",
                                 k, c, alloc_tags[k], m_tag(k));
                    end
                end
            end
            tick();
        end
        clear_inputs();
`ifdef FREE_LIST_CHECK_EN
        #1;
        checks++;
        if (fl_error !== 1'b0) begin
            errors++;
            $display("FAIL rand_no_error: got %0b expected 0", fl_error);
        end
`endif
    endtask

    task automatic test_reset_midop();
        alloc_req = 3'b111;
        tick();
        alloc_req          = 3'b111;
        retire_en          = 3'b001;
        retire_old_tags[0] = PHYS_TAG'(5);
        restore_en         = 1'b1;
        reset              = 1'b0;
        tick();
        reset = 1'b1;
        clear_inputs();
        #1;
        checks++;
        if (free_count !== FL_CNT'(32) || alloc_tags[0] !== PHYS_TAG'(32) ||
            alloc_tags[1] !== PHYS_TAG'(33) || alloc_tags[2] !== PHYS_TAG'(34)) begin
            errors++;
            $display("FAIL midop_reset: got count %0d tags %0d/%0d/%0d expected 32 32/33/34",
                     free_count, alloc_tags[0], alloc_tags[1], alloc_tags[2]);
        end
    endtask

`ifdef FREE_LIST_CHECK_EN
    task automatic test_check();
        do_reset();
        checks++;
        if (fl_error !== 1'b0) begin
            errors++;
            $display("FAIL check_reset: got %0b expected 0", fl_error);
        end
        retire_en          = 3'b001;
        retire_old_tags[0] = '0;
        tick();
        clear_inputs();
        #1;
        checks++;
        if (fl_error !== 1'b1) begin
            errors++;
            $display("FAIL check_set: got %0b expected 1", fl_error);
        end
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (fl_error !== 1'b1) begin
            errors++;
            $display("FAIL check_sticky: got %0b expected 1", fl_error);
        end
        do_reset();
        checks++;
        if (fl_error !== 1'b0) begin
            errors++;
            $display("FAIL check_clear: got %0b expected 0", fl_error);
        end
    endtask
`endif

    initial begin
        clear_inputs();
        reset = 1'b0;
        m_reset();
        test_reset();
        test_alloc();
        test_drain();
        test_retire_then_alloc();
        test_restore();
        test_random();
        test_reset_midop();
`ifdef FREE_LIST_CHECK_EN
        test_check();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
